// File: rtl/ball_serve_if.sv
// Signal bundle between the ball serve controller and the rest of the game logic.
// master drives the game events; slave is the controller that answers with ball control.
interface ball_serve_if;
   logic       frame_tick;
   logic       _hit1;
   logic       _hit2;
   logic       miss_l;
   logic       miss_r;
   logic       attract;
   logic       l;
   logic       r;
   logic       move;
   logic [1:0] speed;
   logic       score1;
   logic       score2;
   logic       serving;

   modport master (
      output frame_tick, _hit1, _hit2, miss_l, miss_r, attract,
      input  l, r, move, speed, score1, score2, serving
   );

   modport slave (
      input  frame_tick, _hit1, _hit2, miss_l, miss_r, attract,
      output l, r, move, speed, score1, score2, serving
   );
endinterface

// File: rtl/ball_serve_controller.sv
// Ball serve/rally controller: holds the ball for a serve, tracks paddle hits for speed,
// and awards points when the ball leaves the field.
module ball_serve_controller #(
   parameter int SERVE_FRAMES = 64,
   parameter int HITS_MED     = 4,
   parameter int HITS_FAST    = 12
) (
   input logic         clk,
   input logic         _reset,
   ball_serve_if.slave bus
);

   localparam int             FW         = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
   localparam logic [FW-1:0]  FRAME_LAST = FW'(SERVE_FRAMES - 1);
   localparam logic [3:0]     MED        = 4'(HITS_MED);
   localparam logic [3:0]     FAST       = 4'(HITS_FAST);

   typedef enum logic [1:0] {ATTRACT, SERVE, PLAY, MISS} state_t;

   state_t        state, state_next;
   logic          hit1_p0, hit2_p0;
   logic          dir_l, dir_l_next;
   logic [3:0]    hit_cnt, hit_cnt_next;
   logic [FW-1:0] frame_cnt, frame_cnt_next;
   logic          score1_next, score2_next;
   logic          move_q, serving_q, score1_q, score2_q;
   logic [1:0]    speed_q;
   logic          edge1, edge2;

   function automatic logic [1:0] speed_of(input logic [3:0] cnt);
      if (cnt < MED)
         return 2'd0;
      else if (cnt < FAST)
         return 2'd1;
      else
         return 2'd2;
   endfunction

   assign edge1 = hit1_p0 & ~bus._hit1;
   assign edge2 = hit2_p0 & ~bus._hit2;

   always_ff @(posedge clk or negedge _reset) begin
      if (!_reset)
         state <= ATTRACT;
      else
         state <= state_next;
   end

   always_comb begin
      state_next     = state;
      dir_l_next     = dir_l;
      hit_cnt_next   = hit_cnt;
      frame_cnt_next = frame_cnt;
      score1_next    = 1'b0;
      score2_next    = 1'b0;

      case (state)
         ATTRACT: begin
            if (bus.miss_l || bus.miss_r)
               dir_l_next = ~dir_l;
            else if (edge1 && !edge2)
               dir_l_next = 1'b0;
            else if (edge2 && !edge1)
               dir_l_next = 1'b1;
            if (!bus.attract) begin
               state_next     = SERVE;
               frame_cnt_next = '0;
               hit_cnt_next   = 4'd0;
            end
         end
         SERVE: begin
            if (bus.frame_tick) begin
               if (frame_cnt == FRAME_LAST)
                  state_next = PLAY;
               else
                  frame_cnt_next = frame_cnt + FW'(1);
            end
         end
         PLAY: begin
            // a miss wins over any hit arriving in the same cycle; miss_l wins over miss_r
            if (bus.miss_l) begin
               score2_next = 1'b1;
               dir_l_next  = 1'b1;
               state_next  = MISS;
            end else if (bus.miss_r) begin
               score1_next = 1'b1;
               dir_l_next  = 1'b0;
               state_next  = MISS;
            end else begin
               if ((edge1 || edge2) && hit_cnt != 4'd15)
                  hit_cnt_next = hit_cnt + 4'd1;
               if (edge1 && !edge2)
                  dir_l_next = 1'b0;
               else if (edge2 && !edge1)
                  dir_l_next = 1'b1;
            end
         end
         MISS: begin
            state_next     = SERVE;
            frame_cnt_next = '0;
            hit_cnt_next   = 4'd0;
         end
         default: state_next = ATTRACT;
      endcase

      // attract mode pre-empts whatever the game was doing this cycle
      if (state != ATTRACT && bus.attract) begin
         state_next     = ATTRACT;
         dir_l_next     = dir_l;
         hit_cnt_next   = hit_cnt;
         frame_cnt_next = frame_cnt;
         score1_next    = 1'b0;
         score2_next    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge _reset) begin
      if (!_reset) begin
         hit1_p0   <= 1'b0;
         hit2_p0   <= 1'b0;
         dir_l     <= 1'b0;
         hit_cnt   <= 4'd0;
         frame_cnt <= '0;
         move_q    <= 1'b0;
         serving_q <= 1'b0;
         score1_q  <= 1'b0;
         score2_q  <= 1'b0;
         speed_q   <= 2'd0;
      end else begin
         hit1_p0   <= bus._hit1;
         hit2_p0   <= bus._hit2;
         dir_l     <= dir_l_next;
         hit_cnt   <= hit_cnt_next;
         frame_cnt <= frame_cnt_next;
         move_q    <= (state_next == ATTRACT) || (state_next == PLAY);
         serving_q <= (state_next == SERVE);
         score1_q  <= score1_next;
         score2_q  <= score2_next;
         // speed follows the registered count, so it trails a hit by one cycle
         speed_q   <= (state_next == PLAY) ? speed_of(hit_cnt) : 2'd0;
      end
   end

   assign bus.l       = dir_l;
   assign bus.r       = ~dir_l;
   assign bus.move    = move_q;
   assign bus.serving = serving_q;
   assign bus.score1  = score1_q;
   assign bus.score2  = score2_q;
   assign bus.speed   = speed_q;

endmodule

// File: tb/tb_ball_serve_controller.sv
// Randomized bench for ball_serve_controller against a behavioural game-rule model.
module tb_ball_serve_controller;

   localparam int SERVE_FRAMES = 64;
   localparam int HITS_MED     = 4;
   localparam int HITS_FAST    = 12;

   logic clk = 1'b0;
   logic _reset;

   ball_serve_if bus ();

   ball_serve_controller #(
      .SERVE_FRAMES(SERVE_FRAMES),
      .HITS_MED    (HITS_MED),
      .HITS_FAST   (HITS_FAST)
   ) dut (
      .clk   (clk),
      ._reset(_reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef enum {M_ATT, M_SRV, M_PLY, M_MIS} mode_t;
   mode_t m_mode;
   bit    m_l;
   int    m_hits, m_frames;
   bit    m_prev1, m_prev2;
   bit    e_move, e_serving, e_s1, e_s2;
   int    e_speed;

   task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int speed_for(input int hits);
      if (hits >= HITS_FAST) return 2;
      if (hits >= HITS_MED)  return 1;
      return 0;
   endfunction

   task automatic model_reset();
      m_mode    = M_ATT;
      m_l       = 1'b0;
      m_hits    = 0;
      m_frames  = 0;
      m_prev1   = 1'b0;
      m_prev2   = 1'b0;
      e_move    = 1'b0;
      e_serving = 1'b0;
      e_s1      = 1'b0;
      e_s2      = 1'b0;
      e_speed   = 0;
   endtask

   // one rising edge of game rules, evaluated from the inputs present at that edge
   task automatic model_step();
      bit f1, f2;
      int old_hits;
      f1 = m_prev1 && !bus._hit1;
      f2 = m_prev2 && !bus._hit2;
      m_prev1 = bus._hit1;
      m_prev2 = bus._hit2;
      old_hits = m_hits;
      e_s1 = 1'b0;
      e_s2 = 1'b0;
      if (m_mode != M_ATT && bus.attract) begin
         m_mode = M_ATT;
      end else begin
         case (m_mode)
            M_ATT: begin
               if (bus.miss_l || bus.miss_r) m_l = !m_l;
               else if (f1 && !f2)           m_l = 1'b0;
               else if (f2 && !f1)           m_l = 1'b1;
               if (!bus.attract) begin
                  m_mode = M_SRV; m_frames = 0; m_hits = 0;
               end
            end
            M_SRV: begin
               if (bus.frame_tick) begin
                  m_frames++;
                  if (m_frames == SERVE_FRAMES) m_mode = M_PLY;
               end
            end
            M_PLY: begin
               if (bus.miss_l) begin
                  e_s2 = 1'b1; m_l = 1'b1; m_mode = M_MIS;
               end else if (bus.miss_r) begin
                  e_s1 = 1'b1; m_l = 1'b0; m_mode = M_MIS;
               end else begin
                  if (f1 || f2) m_hits = (m_hits >= 15) ? 15 : m_hits + 1;
                  if (f1 && !f2)      m_l = 1'b0;
                  else if (f2 && !f1) m_l = 1'b1;
               end
            end
            default: begin
               m_mode = M_SRV; m_frames = 0; m_hits = 0;
            end
         endcase
      end
      e_move    = (m_mode == M_ATT) || (m_mode == M_PLY);
      e_serving = (m_mode == M_SRV);
      e_speed   = (m_mode == M_PLY) ? speed_for(old_hits) : 0;
   endtask

   task automatic check_all();
      bit er;
      er = !m_l;
      chk("l",       4'(bus.l),       4'(m_l));
      chk("r",       4'(bus.r),       4'(er));
      chk("move",    4'(bus.move),    4'(e_move));
      chk("speed",   4'(bus.speed),   4'(e_speed));
      chk("score1",  4'(bus.score1),  4'(e_s1));
      chk("score2",  4'(bus.score2),  4'(e_s2));
      chk("serving", 4'(bus.serving), 4'(e_serving));
   endtask

   task automatic drive(input bit tick, input bit h1, input bit h2,
                        input bit ml, input bit mr, input bit att);
      bus.frame_tick = tick;
      bus._hit1      = h1;
      bus._hit2      = h2;
      bus.miss_l     = ml;
      bus.miss_r     = mr;
      bus.attract    = att;
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   task automatic serve_out();
      for (int i = 0; i < SERVE_FRAMES; i++) begin
         drive(1, 1, 1, 0, 0, 0);
         step();
      end
      drive(0, 1, 1, 0, 0, 0);
   endtask

   initial begin
      bit att, h1, h2;
      drive(0, 1, 1, 0, 0, 0);
      _reset = 1'b0;
      model_reset();
      #12;
      check_all();
      _reset = 1'b1;

      // reset release with attract low goes straight into a serve
      step();
      chk("serve_entered", 4'(bus.serving), 4'd1);
      for (int i = 0; i < SERVE_FRAMES - 1; i++) begin
         drive(1, 1, 1, 0, 0, 0);
         step();
      end
      chk("serve_63_still_held", 4'(bus.move), 4'd0);
      drive(1, 1, 1, 0, 0, 0);
      step();
      drive(0, 1, 1, 0, 0, 0);
      chk("serve_done_move", 4'(bus.move), 4'd1);
      chk("serve_done_serving", 4'(bus.serving), 4'd0);
      chk("serve_done_l", 4'(bus.l), 4'd0);
      chk("serve_done_r", 4'(bus.r), 4'd1);

      // hit counting and speed thresholds
      for (int i = 1; i <= 20; i++) begin
         drive(0, 0, 1, 0, 0, 0);
         step();
         drive(0, 1, 1, 0, 0, 0);
         step();
         if (i == 3)  chk("speed_after_3", 4'(bus.speed), 4'd0);
         if (i == 4)  chk("speed_after_4", 4'(bus.speed), 4'd1);
         if (i == 11) chk("speed_after_11", 4'(bus.speed), 4'd1);
         if (i == 12) chk("speed_after_12", 4'(bus.speed), 4'd2);
         if (i == 20) chk("speed_after_20", 4'(bus.speed), 4'd2);
      end

      // miss on the right: score1 pulse, one-cycle MISS, then serve to the right
      drive(0, 1, 1, 0, 1, 0);
      step();
      chk("miss_r_score1", 4'(bus.score1), 4'd1);
      chk("miss_r_move", 4'(bus.move), 4'd0);
      drive(0, 1, 1, 0, 0, 0);
      step();
      chk("after_miss_score1", 4'(bus.score1), 4'd0);
      chk("after_miss_serving", 4'(bus.serving), 4'd1);
      chk("after_miss_r", 4'(bus.r), 4'd1);
      chk("after_miss_speed", 4'(bus.speed), 4'd0);
      serve_out();

      // both misses plus a hit1 fall in one cycle
      drive(0, 0, 1, 1, 1, 0);
      step();
      chk("double_miss_score2", 4'(bus.score2), 4'd1);
      chk("double_miss_score1", 4'(bus.score1), 4'd0);
      chk("double_miss_l", 4'(bus.l), 4'd1);
      drive(0, 1, 1, 0, 0, 0);
      step();

      // attract raised mid-serve
      for (int i = 0; i < 10; i++) begin
         drive(1, 1, 1, 0, 0, 0);
         step();
      end
      drive(0, 1, 1, 0, 0, 1);
      step();
      chk("attract_move", 4'(bus.move), 4'd1);
      chk("attract_serving", 4'(bus.serving), 4'd0);
      drive(0, 1, 1, 1, 0, 1);
      step();
      chk("attract_toggle_l", 4'(bus.l), 4'd0);
      chk("attract_no_score", 4'(bus.score2), 4'd0);

      // randomized play
      att = 1'b0; h1 = 1'b1; h2 = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 299) == 0) att = !att;
         if ($urandom_range(0, 3) == 0) h1 = !h1;
         if ($urandom_range(0, 3) == 0) h2 = !h2;
         drive(1'($urandom_range(0, 1)), h1, h2,
               $urandom_range(0, 39) == 0, $urandom_range(0, 39) == 0, att);
         step();
      end

      // asynchronous reset in the middle of a rally
      drive(0, 1, 1, 0, 0, 1);
      step();
      drive(0, 1, 1, 0, 0, 0);
      step();
      serve_out();
      for (int i = 0; i < 6; i++) begin
         drive(0, 1, 0, 0, 0, 0);
         step();
         drive(0, 1, 1, 0, 0, 0);
         step();
      end
      chk("pre_reset_speed", 4'(bus.speed), 4'd1);
      #2;
      _reset = 1'b0;
      #1;
      model_reset();
      check_all();
      chk("async_rst_r", 4'(bus.r), 4'd1);
      #3;
      drive(0, 1, 1, 0, 0, 1);
      _reset = 1'b1;
      step();
      chk("rst_release_move", 4'(bus.move), 4'd1);
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ball_serve_controller.md
BALL_SERVE_CONTROLLER -- requirements
Module: ball_serve_controller

Interface
REQ-001 SHALL provide parameter SERVE_FRAMES, default 64: frame ticks the ball is held before a serve.
REQ-002 SHALL provide parameter HITS_MED, default 4: hit count that selects medium speed.
REQ-003 SHALL provide parameter HITS_FAST, default 12: hit count that selects fast speed; HITS_MED < HITS_FAST <= 15.
REQ-004 SHALL have port clk, input, 1: single system clock; all state changes on its rising edge.
REQ-005 SHALL have port _reset, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port frame_tick, input, 1: one-cycle pulse, once per video frame.
REQ-007 SHALL have port _hit1, input, 1: active-low level, paddle 1 (left) contact.
REQ-008 SHALL have port _hit2, input, 1: active-low level, paddle 2 (right) contact.
REQ-009 SHALL have port miss_l, input, 1: one-cycle pulse, ball exited the left edge.
REQ-010 SHALL have port miss_r, input, 1: one-cycle pulse, ball exited the right edge.
REQ-011 SHALL have port attract, input, 1: level, high selects attract mode.
REQ-012 SHALL have ports l and r, output, 1 each: ball horizontal direction; r = ~l at all times.
REQ-013 SHALL have port move, output, 1: high when horizontal motion is enabled.
REQ-014 SHALL have port speed, output, 2: 0 slow, 1 medium, 2 fast; value 3 is never driven.
REQ-015 SHALL have ports score1 and score2, output, 1 each: one-cycle point-award pulses.
REQ-016 SHALL have port serving, output, 1: high while in SERVE state.

Function
REQ-017 SHALL implement states ATTRACT, SERVE, PLAY and MISS, all registered.
REQ-018 SHALL detect a hit on the falling edge of _hit1 or _hit2, using a registered copy of each input.
REQ-019 SHALL, on a hit1 edge, set r=1 and l=0 in the next cycle; a hit2 edge SHALL set l=1 and r=0.
REQ-020 SHALL leave direction unchanged when hit1 and hit2 edges occur in the same cycle, with the hit counter still incremented once.
REQ-021 SHALL, in ATTRACT, drive move=1 and speed=0, toggle direction on miss_l or miss_r, and generate no score pulses.
REQ-022 SHALL leave ATTRACT for SERVE when attract falls, loading the frame counter with 0.
REQ-023 SHALL enter ATTRACT in the next cycle when attract is high in any other state, overriding all other transitions.
REQ-024 SHALL, in SERVE, drive move=0 and serving=1, clear the hit counter on entry, and increment the frame counter on frame_tick.
REQ-025 SHALL transition from SERVE to PLAY on the frame_tick that brings the frame counter to SERVE_FRAMES; the serve is therefore exactly SERVE_FRAMES ticks long.
REQ-026 SHALL ignore hits and misses while in SERVE.
REQ-027 SHALL, in PLAY, drive move=1; each hit SHALL increment a 4-bit hit counter that saturates at 15.
REQ-028 SHALL derive speed from the hit counter: cnt < HITS_MED gives 0; HITS_MED <= cnt < HITS_FAST gives 1; otherwise 2; the output is registered and changes the cycle after the count changes.
REQ-029 SHALL, on miss_l in PLAY, pulse score2 for one cycle and go to MISS; on miss_r, pulse score1 and go to MISS.
REQ-030 SHALL, when miss_l and miss_r arrive together, treat the event as miss_l only.
REQ-031 SHALL, in MISS, drive move=0 for exactly one cycle and then go to SERVE.
REQ-032 SHALL set the serve direction on entry to MISS: after miss_l, l=1; after miss_r, r=1.
REQ-033 SHALL let a miss pulse take priority over a hit edge in the same cycle of PLAY.

Reset
REQ-034 SHALL, while _reset is low, asynchronously force state=ATTRACT, l=0, r=1, move=0, speed=0, score1=0, score2=0, serving=0, and clear all counters and edge registers.
REQ-035 SHALL drive move=1 from the first clock edge after _reset rises, if the block is in ATTRACT.
REQ-036 SHALL, when reset is asserted mid-serve or mid-play, discard all progress with no score pulse emitted.

Verification
REQ-037 The bench SHALL cover: reset release with attract=0 -> SERVE is entered; after 64 frame_ticks -> move=1, serving=0, l=0, r=1.
REQ-038 The bench SHALL cover: in PLAY, 4 hit1 edges -> speed=1; 12 hits -> speed=2; 20 hits -> counter stays at 15, speed=2.
REQ-039 The bench SHALL cover: in PLAY, miss_r pulse -> score1=1 for 1 cycle; MISS lasts 1 cycle; SERVE follows with r=1, hit counter 0, speed 0.
REQ-040 The bench SHALL cover: same-cycle miss_l, miss_r and _hit1 fall -> only score2 pulses; l=1; no direction change from the hit.
REQ-041 The bench SHALL cover: attract raised mid-SERVE -> ATTRACT next cycle with move=1; a subsequent miss_l toggles direction with no score pulse.
REQ-042 The bench SHALL cover: _reset pulsed low asynchronously mid-PLAY -> all outputs reach reset values without a clock edge.
